decode_queue: RTL and testbench
===============================

# decode_queue

Buffered, parametrised instruction-decode stage between fetch and issue. Fetched words with their PCs enter a DEPTH-entry FIFO through a valid/ready handshake. The FIFO head is decoded, with strict funct7 checking and an optional M extension. Results are registered into an output stage with its own valid/ready handshake. A synchronous flush discards all buffered and in-flight instructions on redirect.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- M_EXT, 1, 1 = RV32M decoded; 0 = any M encoding is illegal
- PC_WIDTH, 32, width of PC fields
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous discard of FIFO and output stage
- in_valid  in  1  fetch word present
- in_ready  out  1  FIFO can accept
- in_pc  in  PC_WIDTH  PC of in_instr
- in_instr  in  32  instruction word
- out_valid  out  1  decoded instruction present
- out_ready  in  1  consumer accepts
- out_pc  out  PC_WIDTH  PC of decoded instruction
- out_instr  out  32  raw word, used as mtval on illegal
- out_dec  out  decoder_out_type  decoded fields (imm, enables, op structs, flags, valid)
- out_illegal  out  1  equals ~out_dec.valid while out_valid
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding output stage

## Operation
- Push: in_valid && in_ready at an edge writes {pc, instr} at wr_ptr. wr_ptr wraps modulo DEPTH.
- in_ready = (count < DEPTH) && !reset. It is registered-count based and never depends on out_ready or flush.
- Output stage load: when FIFO is non-empty and (!out_valid || out_ready), the decoded head is loaded, rd_ptr advances and out_valid=1. If the FIFO is empty and out_ready is high, out_valid goes to 0.
- Same-edge push and pop leaves count unchanged. When full, no push occurs even if a pop happens that edge.
- Hold: while out_valid && !out_ready, all out_* signals are stable.
- Decode (combinational on FIFO head) uses the standard RV32I opcode classes: lui, auipc, jal, jalr, branch, load, store, op-imm, op, fence, system.
  - wren is forced 0 when rd = x0.
  - CSR crden/cwren follow the rd=x0 / rs1-or-uimm=0 suppression rules.
- Strict checks, new in this block. Each sets valid = 0:
  - op: funct7 must be 0000000; or 0100000 with funct3 ∈ {add, srl}; or 0000001 with M_EXT=1.
  - op-imm shifts: funct7 must be 0000000 for slli/srli, 0100000 for srai.
  - branch funct3 010/011, load funct3 011/110/111, store funct3 ≥ 011.
  - system funct3 = 100.
  - system funct3 = 000 with an unknown imm.
  - fence funct3 ∉ {000, 001}.
  - Unknown opcode.
  - Instruction bits [1:0] ≠ 11.
- Fence: funct3 001 sets fence = 1. funct3 000 decodes as a valid no-op.
- Illegal sanitising: when valid = 0, out_dec.wren, cwren, crden, rden1, rden2, load, store, csr, muldiv, jal, jalr and branch are forced 0. All op structs are zeroed, imm = 0. out_instr carries the raw word.
- The canonical nop (0x00000013) decodes with alu_add = 0 and valid = 1.
- Flush: at an edge with flush = 1:
  - count, wr_ptr and rd_ptr go to 0, and out_valid goes to 0.
  - A simultaneous push is dropped and a simultaneous output load is suppressed.
  - Flush has priority over every other event.

## Timing
- Reset (async assert, sync release), values while asserted:
  - count = 0, pointers = 0, in_ready = 0, out_valid = 0.
  - out_pc = 0, out_instr = 0, out_dec = all zero, out_illegal = 0.
- Latency: a word accepted at edge t0 appears with out_valid = 1 after edge t1 (one cycle), provided the output stage is free or drained at t1.
- Throughput: one instruction per cycle with continuous in_valid and out_ready.
- Total capacity is DEPTH+1 with stalled output; in_ready falls the cycle after count reaches DEPTH.
- After a stall releases, in_ready rises the cycle after the first pop.
- out_illegal and out_dec are registered; no combinational path exists from in_* to out_*.

## Test plan
- Reset, then stream 8 words at PC 0x0,0x4,…; out_ready = 1 → out_valid from cycle 2, one per cycle, PCs in order, count ≤ 1.
- out_ready = 0, push DEPTH+2 words → exactly DEPTH+1 accepted, in_ready = 0 with count = 4 (DEPTH = 4). Release → all drain in order; wr_ptr wraps cleanly.
- 0x02C58533 (mul a0,a1,a2):
  - M_EXT = 1 → muldiv = 1, muldiv_mul = 1, valid = 1.
  - M_EXT = 0 → out_illegal = 1, wren = 0, out_instr = 0x02C58533.
- Strict funct7 checks:
  - 0x40B51533 (funct7 0100000 with sll) → illegal.
  - 0x40B55533 (sra) → alu_sra = 1, valid.
  - 0x00051513 (slli a0,a0,0) → valid.
- Flush mid-stream with 3 queued, 1 in output, and push plus pop on the same edge → next cycle count = 0, out_valid = 0, dropped word never appears.
- Assert reset while count = 2 and out_valid = 1 → outputs zero immediately, without waiting for a clock edge. After release, in_ready = 1 and the first new word is output correctly.

Source files
------------

// File: rtl/decode_queue_if.sv
// Decoded-instruction types and the fetch/issue handshake bundle of decode_queue.
// The master modport is the fetch+issue environment, the slave modport is the queue.
package decode_queue_pkg;
  typedef struct packed {
    logic alu_add, alu_sub, alu_sll, alu_slt, alu_sltu;
    logic alu_xor, alu_srl, alu_sra, alu_or, alu_and;
  } alu_op_type;

  typedef struct packed {
    logic beq, bne, blt, bge, bltu, bgeu;
  } bcu_op_type;

  typedef struct packed {
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
  } lsu_op_type;

  typedef struct packed {
    logic csrrw, csrrs, csrrc;
  } csr_op_type;

  typedef struct packed {
    logic muldiv_mul, muldiv_mulh, muldiv_mulhsu, muldiv_mulhu;
    logic muldiv_div, muldiv_divu, muldiv_rem, muldiv_remu;
  } mul_op_type;

  typedef struct packed {
    logic [31:0] imm;
    logic [11:0] caddr;
    logic [4:0]  waddr, raddr1, raddr2;
    logic        wren, rden1, rden2, cwren, crden;
    alu_op_type  alu;
    bcu_op_type  bcu;
    lsu_op_type  lsu;
    csr_op_type  csr_op;
    mul_op_type  mul_op;
    logic        lui, auipc, jal, jalr, branch, load, store, csr, muldiv;
    logic        fence, ecall, ebreak, mret, wfi;
    logic        valid;
  } decoder_out_type;
endpackage

interface decode_queue_if #(parameter int PC_WIDTH = 32);
  logic                            in_valid;
  logic                            in_ready;
  logic [PC_WIDTH-1:0]             in_pc;
  logic [31:0]                     in_instr;
  logic                            out_valid;
  logic                            out_ready;
  logic [PC_WIDTH-1:0]             out_pc;
  logic [31:0]                     out_instr;
  decode_queue_pkg::decoder_out_type out_dec;
  logic                            out_illegal;

  modport master (output in_valid, in_pc, in_instr, out_ready,
                  input  in_ready, out_valid, out_pc, out_instr, out_dec, out_illegal);
  modport slave  (input  in_valid, in_pc, in_instr, out_ready,
                  output in_ready, out_valid, out_pc, out_instr, out_dec, out_illegal);
endinterface

// File: rtl/decode_queue.sv
// Fetch-to-issue buffer: DEPTH-entry FIFO, strict RV32I(+M) decode of the head,
// registered output stage, synchronous flush for redirects.
module decode_queue #(
  parameter int DEPTH    = 4,
  parameter bit M_EXT    = 1'b1,
  parameter int PC_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  decode_queue_if.slave            q_if,
  output logic [$clog2(DEPTH):0]   o_count
);
  import decode_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [PC_WIDTH-1:0] r_mem_pc  [DEPTH];
  logic [31:0]         r_mem_ins [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_count;

  logic                r_out_valid, r_out_illegal;
  logic [PC_WIDTH-1:0] r_out_pc;
  logic [31:0]         r_out_instr;
  decoder_out_type     r_out_dec;

  logic                w_push, w_load, w_empty, w_ok;
  logic [31:0]         w_ins;
  logic [4:0]          w_rd, w_rs1, w_rs2;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  decoder_out_type     w_dec;

  // in_ready depends only on registered occupancy, so a full FIFO refuses
  // a push even on an edge that also pops.
  assign q_if.in_ready = (r_count != (AW+1)'(DEPTH)) && !i_rst;
  assign w_empty       = (r_count == '0);
  assign w_push        = q_if.in_valid && q_if.in_ready && !i_flush;
  assign w_load        = !w_empty && (!r_out_valid || q_if.out_ready) && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]  <= q_if.in_pc;
      r_mem_ins[r_wr_ptr] <= q_if.in_instr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  function automatic alu_op_type alu_f3(input logic [2:0] f3, input logic alt);
    alu_op_type a;
    a = '0;
    case (f3)
      3'b000: if (alt) a.alu_sub = 1'b1; else a.alu_add = 1'b1;
      3'b001: a.alu_sll  = 1'b1;
      3'b010: a.alu_slt  = 1'b1;
      3'b011: a.alu_sltu = 1'b1;
      3'b100: a.alu_xor  = 1'b1;
      3'b101: if (alt) a.alu_sra = 1'b1; else a.alu_srl = 1'b1;
      3'b110: a.alu_or   = 1'b1;
      default: a.alu_and = 1'b1;
    endcase
    return a;
  endfunction

  assign w_ins = r_mem_ins[r_rd_ptr];
  assign w_rd  = w_ins[11:7];
  assign w_rs1 = w_ins[19:15];
  assign w_rs2 = w_ins[24:20];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];

  always_comb begin
    w_dec        = '0;
    w_ok         = 1'b1;
    w_dec.waddr  = w_rd;
    w_dec.raddr1 = w_rs1;
    w_dec.raddr2 = w_rs2;
    case (w_ins[6:2])
      OPC_LUI: begin
        w_dec.wren = 1'b1; w_dec.lui = 1'b1;
        w_dec.imm  = {w_ins[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        w_dec.wren = 1'b1; w_dec.auipc = 1'b1;
        w_dec.imm  = {w_ins[31:12], 12'b0};
      end
      OPC_JAL: begin
        w_dec.wren = 1'b1; w_dec.jal = 1'b1;
        w_dec.imm  = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_dec.wren = 1'b1; w_dec.rden1 = 1'b1; w_dec.jalr = 1'b1;
        w_dec.imm  = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      OPC_BRANCH: begin
        w_dec.rden1 = 1'b1; w_dec.rden2 = 1'b1; w_dec.branch = 1'b1;
        w_dec.imm   = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        case (w_f3)
          3'b000: w_dec.bcu.beq  = 1'b1;
          3'b001: w_dec.bcu.bne  = 1'b1;
          3'b100: w_dec.bcu.blt  = 1'b1;
          3'b101: w_dec.bcu.bge  = 1'b1;
          3'b110: w_dec.bcu.bltu = 1'b1;
          3'b111: w_dec.bcu.bgeu = 1'b1;
          default: w_ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_dec.wren = 1'b1; w_dec.rden1 = 1'b1; w_dec.load = 1'b1;
        w_dec.imm  = {{20{w_ins[31]}}, w_ins[31:20]};
        case (w_f3)
          3'b000: w_dec.lsu.lb  = 1'b1;
          3'b001: w_dec.lsu.lh  = 1'b1;
          3'b010: w_dec.lsu.lw  = 1'b1;
          3'b100: w_dec.lsu.lbu = 1'b1;
          3'b101: w_dec.lsu.lhu = 1'b1;
          default: w_ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_dec.rden1 = 1'b1; w_dec.rden2 = 1'b1; w_dec.store = 1'b1;
        w_dec.imm   = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        case (w_f3)
          3'b000: w_dec.lsu.sb = 1'b1;
          3'b001: w_dec.lsu.sh = 1'b1;
          3'b010: w_dec.lsu.sw = 1'b1;
          default: w_ok = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        w_dec.wren  = 1'b1; w_dec.rden1 = 1'b1;
        w_dec.imm   = {{20{w_ins[31]}}, w_ins[31:20]};
        w_dec.alu   = alu_f3(w_f3, w_f3 == 3'b101 && w_f7 == 7'b0100000);
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_ok = 1'b0;
        if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_ok = 1'b0;
        // addi x0,x0,0 is a pure bubble; downstream must not see an ALU op.
        if (w_ins == 32'h0000_0013) w_dec.alu = '0;
      end
      OPC_OP: begin
        w_dec.wren = 1'b1; w_dec.rden1 = 1'b1; w_dec.rden2 = 1'b1;
        case (w_f7)
          7'b0000000: w_dec.alu = alu_f3(w_f3, 1'b0);
          7'b0100000: begin
            if (w_f3 == 3'b000 || w_f3 == 3'b101) w_dec.alu = alu_f3(w_f3, 1'b1);
            else w_ok = 1'b0;
          end
          7'b0000001: begin
            if (M_EXT) begin
              w_dec.muldiv = 1'b1;
              w_dec.mul_op = mul_op_type'(8'b1000_0000 >> w_f3);
            end else begin
              w_ok = 1'b0;
            end
          end
          default: w_ok = 1'b0;
        endcase
      end
      OPC_FENCE: begin
        if (w_f3 == 3'b001) w_dec.fence = 1'b1;
        else if (w_f3 != 3'b000) w_ok = 1'b0;
      end
      OPC_SYSTEM: begin
        if (w_f3 == 3'b000) begin
          case (w_ins[31:20])
            12'h000: w_dec.ecall  = 1'b1;
            12'h001: w_dec.ebreak = 1'b1;
            12'h302: w_dec.mret   = 1'b1;
            12'h105: w_dec.wfi    = 1'b1;
            default: w_ok = 1'b0;
          endcase
        end else if (w_f3 == 3'b100) begin
          w_ok = 1'b0;
        end else begin
          // csrrw never reads when rd=x0; csrrs/csrrc never write when rs1/uimm=0.
          w_dec.csr   = 1'b1;
          w_dec.caddr = w_ins[31:20];
          w_dec.wren  = 1'b1;
          w_dec.rden1 = !w_f3[2];
          if (w_f3[2]) w_dec.imm = {27'b0, w_rs1};
          w_dec.csr_op.csrrw = (w_f3[1:0] == 2'b01);
          w_dec.csr_op.csrrs = (w_f3[1:0] == 2'b10);
          w_dec.csr_op.csrrc = (w_f3[1:0] == 2'b11);
          w_dec.cwren = (w_f3[1:0] == 2'b01) ? 1'b1 : (w_rs1 != 5'd0);
          w_dec.crden = (w_f3[1:0] == 2'b01) ? (w_rd != 5'd0) : 1'b1;
        end
      end
      default: w_ok = 1'b0;
    endcase
    if (w_ins[1:0] != 2'b11) w_ok = 1'b0;
    if (w_rd == 5'd0) w_dec.wren = 1'b0;
    w_dec.valid = w_ok;
    // Illegal words carry nothing actionable downstream; out_instr keeps the raw bits.
    if (!w_ok) w_dec = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
      r_out_pc      <= '0;
      r_out_instr   <= '0;
      r_out_dec     <= '0;
    end else if (i_flush) begin
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (w_load) begin
      r_out_valid   <= 1'b1;
      r_out_illegal <= !w_dec.valid;
      r_out_pc      <= r_mem_pc[r_rd_ptr];
      r_out_instr   <= w_ins;
      r_out_dec     <= w_dec;
    end else if (q_if.out_ready) begin
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
    end
  end

  assign q_if.out_valid   = r_out_valid;
  assign q_if.out_illegal = r_out_illegal;
  assign q_if.out_pc      = r_out_pc;
  assign q_if.out_instr   = r_out_instr;
  assign q_if.out_dec     = r_out_dec;
  assign o_count          = r_count;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: streaming, stall/backpressure, decode legality,
// flush and asynchronous reset; a second M_EXT=0 instance shadows the same stimulus.
module tb_decode_queue;
  logic       clk = 1'b0;
  logic       rst, flush;
  logic [2:0] cnt0, cnt1;
  int         n_chk = 0;
  int         n_err = 0;

  decode_queue_if #(.PC_WIDTH(32)) q0 ();
  decode_queue_if #(.PC_WIDTH(32)) q1 ();

  assign q1.in_valid  = q0.in_valid;
  assign q1.in_pc     = q0.in_pc;
  assign q1.in_instr  = q0.in_instr;
  assign q1.out_ready = q0.out_ready;

  decode_queue #(.DEPTH(4), .M_EXT(1'b1), .PC_WIDTH(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .q_if(q0.slave), .o_count(cnt0));
  decode_queue #(.DEPTH(4), .M_EXT(1'b0), .PC_WIDTH(32)) u_dut_m0 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .q_if(q1.slave), .o_count(cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // push one word into an empty queue with out_ready=1; it is in the output stage on return
  task automatic send1(input logic [31:0] pc, input logic [31:0] ins);
    q0.in_valid = 1'b1; q0.in_pc = pc; q0.in_instr = ins; q0.out_ready = 1'b1;
    step();
    q0.in_valid = 1'b0;
    step();
  endtask

  function automatic logic [31:0] addi_a0(input int k);
    logic [11:0] im;
    im = 12'(k);
    return {im, 5'd10, 3'b000, 5'd10, 7'h13};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0;
    q0.in_valid = 1'b0; q0.in_pc = '0; q0.in_instr = '0; q0.out_ready = 1'b0;
    #1;
    chk("rst_count", cnt0, 0);
    chk("rst_in_ready", q0.in_ready, 0);
    chk("rst_out_valid", q0.out_valid, 0);
    chk("rst_out_pc", q0.out_pc, 0);
    chk("rst_out_dec", |q0.out_dec, 0);
    chk("rst_illegal", q0.out_illegal, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready", q0.in_ready, 1);

    // streaming: one per cycle, one-cycle latency
    q0.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      q0.in_valid = (i < 8); q0.in_pc = 32'(4 * i); q0.in_instr = addi_a0(i);
      step();
      if (i == 0) chk("stream_lat", q0.out_valid, 0);
      else if (i <= 8) begin
        chk("stream_valid", q0.out_valid, 1);
        chk("stream_pc", q0.out_pc, 32'(4 * (i - 1)));
      end else chk("stream_drained", q0.out_valid, 0);
      chk("stream_count", cnt0, (i < 8) ? 1 : 0);
    end
    q0.in_valid = 1'b0;

    // stall: DEPTH+2 offered, DEPTH+1 accepted
    q0.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      q0.in_valid = 1'b1; q0.in_pc = 32'h100 + 32'(4 * k); q0.in_instr = addi_a0(k);
      step();
    end
    q0.in_valid = 1'b0;
    chk("full_count", cnt0, 4);
    chk("full_in_ready", q0.in_ready, 0);
    chk("full_out_pc", q0.out_pc, 32'h100);
    step();
    chk("hold_out_pc", q0.out_pc, 32'h100);
    chk("hold_out_instr", q0.out_instr, addi_a0(0));
    q0.out_ready = 1'b1;
    step();
    chk("release_in_ready", q0.in_ready, 1);
    chk("release_count", cnt0, 3);
    chk("release_pc", q0.out_pc, 32'h104);
    for (int k = 2; k < 5; k++) begin
      step();
      chk("drain_pc", q0.out_pc, 32'h100 + 32'(4 * k));
    end
    step();
    chk("drain_empty", q0.out_valid, 0);

    // M extension
    send1(32'h500, 32'h02C58533);
    chk("mul_valid", q0.out_dec.valid, 1);
    chk("mul_muldiv", q0.out_dec.muldiv, 1);
    chk("mul_op", q0.out_dec.mul_op.muldiv_mul, 1);
    chk("mul_illegal", q0.out_illegal, 0);
    chk("m0_illegal", q1.out_illegal, 1);
    chk("m0_wren", q1.out_dec.wren, 0);
    chk("m0_instr", q1.out_instr, 32'h02C58533);
    chk("m0_muldiv", q1.out_dec.muldiv, 0);

    // strict decode
    send1(32'h504, 32'h40B51533);
    chk("sll_alt_illegal", q0.out_illegal, 1);
    chk("sll_alt_wren", q0.out_dec.wren, 0);
    send1(32'h508, 32'h40B55533);
    chk("sra_valid", q0.out_dec.valid, 1);
    chk("sra_alu", q0.out_dec.alu.alu_sra, 1);
    send1(32'h50C, 32'h00051513);
    chk("slli0_valid", q0.out_dec.valid, 1);
    chk("slli0_alu", q0.out_dec.alu.alu_sll, 1);
    send1(32'h510, 32'h00000013);
    chk("nop_valid", q0.out_dec.valid, 1);
    chk("nop_alu_add", q0.out_dec.alu.alu_add, 0);
    chk("nop_wren", q0.out_dec.wren, 0);
    send1(32'h514, 32'h00000000);
    chk("bits10_illegal", q0.out_illegal, 1);
    send1(32'h518, 32'h0000100F);
    chk("fence_i", {q0.out_dec.valid, q0.out_dec.fence}, 2'b11);
    send1(32'h51C, 32'h00004073);
    chk("sys_f3_100", q0.out_illegal, 1);
    send1(32'h520, 32'h30051073);
    chk("csrrw_x0", {q0.out_dec.cwren, q0.out_dec.crden, q0.out_dec.wren}, 3'b100);
    send1(32'h524, 32'h30002573);
    chk("csrrs_zero", {q0.out_dec.cwren, q0.out_dec.crden, q0.out_dec.wren}, 3'b011);
    send1(32'h528, 32'h12303503);
    chk("ld_illegal", q0.out_illegal, 1);
    chk("ld_imm", q0.out_dec.imm, 0);
    chk("ld_load", q0.out_dec.load, 0);
    chk("ld_instr", q0.out_instr, 32'h12303503);
    chk("ld_pc", q0.out_pc, 32'h528);
    step();

    // flush with 3 queued, 1 in output, push+pop on the flush edge
    q0.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      q0.in_valid = 1'b1; q0.in_pc = 32'h200 + 32'(4 * k); q0.in_instr = addi_a0(k);
      step();
    end
    chk("pre_flush_count", cnt0, 3);
    chk("pre_flush_pc", q0.out_pc, 32'h200);
    flush = 1'b1; q0.in_pc = 32'h210; q0.in_instr = addi_a0(99); q0.out_ready = 1'b1;
    step();
    flush = 1'b0; q0.in_valid = 1'b0;
    chk("flush_count", cnt0, 0);
    chk("flush_out_valid", q0.out_valid, 0);
    step(); step();
    chk("flush_no_ghost", q0.out_valid, 0);
    chk("flush_count2", cnt0, 0);

    // asynchronous reset mid-traffic
    q0.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q0.in_valid = 1'b1; q0.in_pc = 32'h300 + 32'(4 * k); q0.in_instr = addi_a0(k);
      step();
    end
    q0.in_valid = 1'b0;
    chk("pre_rst_count", cnt0, 2);
    chk("pre_rst_valid", q0.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", cnt0, 0);
    chk("arst_valid", q0.out_valid, 0);
    chk("arst_pc", q0.out_pc, 0);
    chk("arst_instr", q0.out_instr, 0);
    chk("arst_dec", |q0.out_dec, 0);
    chk("arst_in_ready", q0.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", q0.in_ready, 1);
    send1(32'h400, 32'h00A00513);
    chk("post_rst_pc", q0.out_pc, 32'h400);
    chk("post_rst_instr", q0.out_instr, 32'h00A00513);
    chk("post_rst_imm", q0.out_dec.imm, 10);
    chk("post_rst_wren", {q0.out_dec.valid, q0.out_dec.wren}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
